dmem_arbiter: RTL

- Sequences and shares the data-RAM command port between three requesters: core source read, core destination write, and the external host (t_cs/t_rw side).
- Host accesses run as multi-beat bursts with auto-incrementing address.
- Arbiter drives the registered en_b/rw/cs/addr command bus into the banked data RAM.
- Sits between the ins_decoder/sprf address path, the host interface and dat_ram.

---
 rtl/dmem_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the data-RAM command port between three requesters:
//   * core source read      (core_rd_req / core_rd_addr / core_rd_gnt)
//   * core destination write (core_wr_req / core_wr_addr / core_wr_gnt)
//   * external host bursts  (host_req / host_rw / host_addr / host_len)
// and drives the registered en_b/rw/cs/addr command bus of the banked RAM.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   core_rd_*          core read request/address in, one-cycle grant out
//   core_wr_*          core write request/address in, one-cycle grant out
//   host_req/rw/addr/len  burst request; rw/addr/len sampled at grant
//   host_gnt           pulse with the first beat of a burst
//   host_beat          high every cycle a host beat is on the RAM bus
//   host_done          pulse with the last beat of a burst
//   core_stall         a pending core request lost arbitration at the last edge
//   dram_en_b/rw/cs/addr  registered RAM command bus (en_b active-low,
//                         rw 1=read, cs one-hot bank select, bank-local addr)
//
// Handshake: a request is sampled at a clock edge; grant and the matching RAM
// command appear together in the following cycle. A requester whose grant is
// high in the current cycle is not eligible at the next edge, so a requester
// may drop (or re-present) its request in the grant cycle.
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int SUB_ADDR_W = 8,
    parameter int LEN_W      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              core_rd_req,
    input  logic [ADDR_W-1:0]                 core_rd_addr,
    output logic                              core_rd_gnt,
    input  logic                              core_wr_req,
    input  logic [ADDR_W-1:0]                 core_wr_addr,
    output logic                              core_wr_gnt,
    input  logic                              host_req,
    input  logic                              host_rw,
    input  logic [ADDR_W-1:0]                 host_addr,
    input  logic [LEN_W-1:0]                  host_len,
    output logic                              host_gnt,
    output logic                              host_beat,
    output logic                              host_done,
    output logic                              core_stall,
    output logic                              dram_en_b,
    output logic                              dram_rw,
    output logic [2**(ADDR_W-SUB_ADDR_W)-1:0] dram_cs,
    output logic [SUB_ADDR_W-1:0]             dram_addr
);

    localparam int CS_W = 2**(ADDR_W-SUB_ADDR_W);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_n;
    logic                last_host_q, last_host_n;
    logic [LEN_W-1:0]    cnt_q, cnt_n;       // beats still to issue in BURST
    logic [ADDR_W-1:0]   baddr_q, baddr_n;   // address of the next burst beat
    logic                brw_q, brw_n;

    logic                rd_gnt_n, wr_gnt_n, host_gnt_n, beat_n, done_n, stall_n;
    logic                en_b_n, rw_n;
    logic [CS_W-1:0]     cs_n;
    logic [SUB_ADDR_W-1:0] addr_n;

    logic                rd_elig, wr_elig, host_elig, core_elig;
    logic                cmd_valid, cmd_rw;
    logic [ADDR_W-1:0]   cmd_addr;

    // A grant visible this cycle blocks the same requester at the next edge.
    assign rd_elig   = core_rd_req & ~core_rd_gnt;
    assign wr_elig   = core_wr_req & ~core_wr_gnt;
    assign host_elig = host_req & ~host_gnt;
    assign core_elig = rd_elig | wr_elig;

    always_comb begin
        state_n     = state_q;
        last_host_n = last_host_q;
        cnt_n       = cnt_q;
        baddr_n     = baddr_q;
        brw_n       = brw_q;
        rd_gnt_n    = 1'b0;
        wr_gnt_n    = 1'b0;
        host_gnt_n  = 1'b0;
        beat_n      = 1'b0;
        done_n      = 1'b0;
        stall_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_rw      = 1'b1;
        cmd_addr    = '0;

        case (state_q)
            IDLE: begin
                // Host wins over the core class only when it did not have the
                // previous turn (or the core class is not asking).
                if (host_elig && (!core_elig || !last_host_q)) begin
                    host_gnt_n  = 1'b1;
                    beat_n      = 1'b1;
                    cmd_valid   = 1'b1;
                    cmd_rw      = host_rw;
                    cmd_addr    = host_addr;
                    brw_n       = host_rw;
                    baddr_n     = host_addr + ADDR_W'(1);
                    cnt_n       = host_len;
                    last_host_n = 1'b1;
                    stall_n     = core_elig;
                    if (host_len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = BURST;
                    end
                end else if (wr_elig) begin
                    wr_gnt_n    = 1'b1;
                    cmd_valid   = 1'b1;
                    cmd_rw      = 1'b0;
                    cmd_addr    = core_wr_addr;
                    last_host_n = 1'b0;
                    stall_n     = rd_elig;
                end else if (rd_elig) begin
                    rd_gnt_n    = 1'b1;
                    cmd_valid   = 1'b1;
                    cmd_rw      = 1'b1;
                    cmd_addr    = core_rd_addr;
                    last_host_n = 1'b0;
                end
            end
            BURST: begin
                beat_n    = 1'b1;
                cmd_valid = 1'b1;
                cmd_rw    = brw_q;
                cmd_addr  = baddr_q;
                baddr_n   = baddr_q + ADDR_W'(1);
                cnt_n     = cnt_q - LEN_W'(1);
                stall_n   = core_elig;
                // The last beat leaves in IDLE so arbitration resumes at the
                // very next edge.
                if (cnt_q == LEN_W'(1)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        en_b_n = 1'b1;
        rw_n   = 1'b1;
        cs_n   = dram_cs;
        addr_n = dram_addr;
        if (cmd_valid) begin
            en_b_n = 1'b0;
            rw_n   = cmd_rw;
            cs_n   = CS_W'(1) << cmd_addr[ADDR_W-1:SUB_ADDR_W];
            addr_n = cmd_addr[SUB_ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_host_q <= 1'b0;
            cnt_q       <= '0;
            baddr_q     <= '0;
            brw_q       <= 1'b1;
            core_rd_gnt <= 1'b0;
            core_wr_gnt <= 1'b0;
            host_gnt    <= 1'b0;
            host_beat   <= 1'b0;
            host_done   <= 1'b0;
            core_stall  <= 1'b0;
            dram_en_b   <= 1'b1;
            dram_rw     <= 1'b1;
            dram_cs     <= '0;
            dram_addr   <= '0;
        end else begin
            state_q     <= state_n;
            last_host_q <= last_host_n;
            cnt_q       <= cnt_n;
            baddr_q     <= baddr_n;
            brw_q       <= brw_n;
            core_rd_gnt <= rd_gnt_n;
            core_wr_gnt <= wr_gnt_n;
            host_gnt    <= host_gnt_n;
            host_beat   <= beat_n;
            host_done   <= done_n;
            core_stall  <= stall_n;
            dram_en_b   <= en_b_n;
            dram_rw     <= rw_n;
            dram_cs     <= cs_n;
            dram_addr   <= addr_n;
        end
    end

endmodule
